// File: rtl/dram_load_sequencer.sv
// DRAM load sequencer: streams three DRAM regions (input, weight, signal) as one
// back-to-back read burst and steers the returning data into the input buffer or
// the shared weight/signal buffer after a fixed read latency.
// Optional feature: define DRAM_SEQ_RANGE_CHECK_EN to skip regions with finish < start
// and flag them on err_o.
module dram_load_sequencer #(
  parameter int unsigned DRAM_ADDR_WIDTH          = 18,
  parameter int unsigned SIG_ADDRS_WIDTH          = 16,
  parameter int unsigned INPUT_FEATURE_ADDR_WIDTH = 16,
  parameter int unsigned DRAM_RD_LATENCY          = 2
) (
  input  logic                                clk_i,
  input  logic                                general_rst_i,
  input  logic                                start_i,
  input  logic [DRAM_ADDR_WIDTH-1:0]          input_start_addr_dram_i,
  input  logic [DRAM_ADDR_WIDTH-1:0]          input_finish_addr_dram_i,
  input  logic [DRAM_ADDR_WIDTH-1:0]          weight_start_addr_dram_i,
  input  logic [DRAM_ADDR_WIDTH-1:0]          weight_finish_addr_dram_i,
  input  logic [DRAM_ADDR_WIDTH-1:0]          signal_start_addr_dram_i,
  input  logic [DRAM_ADDR_WIDTH-1:0]          signal_finish_addr_dram_i,
  output logic                                dram_rd_en_o,
  output logic [DRAM_ADDR_WIDTH-1:0]          dram_rd_address_o,
  output logic                                input_wr_en_o,
  output logic [INPUT_FEATURE_ADDR_WIDTH-1:0] input_wr_address_o,
  output logic                                weight_signal_wr_en_o,
  output logic [SIG_ADDRS_WIDTH-1:0]          weight_signal_wr_address_o,
  output logic                                busy_o,
  output logic                                done_o,
  output logic                                err_o
);

  localparam int unsigned AW = DRAM_ADDR_WIDTH;
  localparam logic [3:0] DrainLast = 4'(DRAM_RD_LATENCY - 1);

  typedef enum logic [2:0] {
    StIdle, StLdInput, StLdWeight, StLdSignal, StDrain, StDone
  } state_e;

  state_e state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] in_start_q, in_start_d, in_fin_q, in_fin_d;
  logic [AW-1:0] w_start_q, w_start_d, w_fin_q, w_fin_d;
  logic [AW-1:0] s_start_q, s_start_d, s_fin_q, s_fin_d;
  logic [3:0] drain_q, drain_d;
  logic [INPUT_FEATURE_ADDR_WIDTH-1:0] in_cnt_q, in_cnt_d;
  logic [SIG_ADDRS_WIDTH-1:0] ws_cnt_q, ws_cnt_d;
  logic [DRAM_RD_LATENCY-1:0] pipe_en_q, pipe_en_d, pipe_tag_q, pipe_tag_d;
  logic err_q, err_d;

  // In IDLE the bounds are not latched yet, so region checks look at the ports.
  logic [AW-1:0] eff_in_start, eff_in_fin, eff_w_start, eff_w_fin, eff_s_start, eff_s_fin;
  logic in_ok, w_ok, s_ok;
  logic rd_en, go_in, go_w, go_s, go_drain;

  assign eff_in_start = (state_q == StIdle) ? input_start_addr_dram_i   : in_start_q;
  assign eff_in_fin   = (state_q == StIdle) ? input_finish_addr_dram_i  : in_fin_q;
  assign eff_w_start  = (state_q == StIdle) ? weight_start_addr_dram_i  : w_start_q;
  assign eff_w_fin    = (state_q == StIdle) ? weight_finish_addr_dram_i : w_fin_q;
  assign eff_s_start  = (state_q == StIdle) ? signal_start_addr_dram_i  : s_start_q;
  assign eff_s_fin    = (state_q == StIdle) ? signal_finish_addr_dram_i : s_fin_q;

`ifdef DRAM_SEQ_RANGE_CHECK_EN
  assign in_ok = (eff_in_fin >= eff_in_start);
  assign w_ok  = (eff_w_fin >= eff_w_start);
  assign s_ok  = (eff_s_fin >= eff_s_start);
  assign err_o = err_q;
`else
  // Inverted regions simply read upward through the address wrap.
  assign in_ok = 1'b1;
  assign w_ok  = 1'b1;
  assign s_ok  = 1'b1;
  assign err_o = 1'b0;
`endif

  assign rd_en = (state_q == StLdInput) || (state_q == StLdWeight) || (state_q == StLdSignal);

  // Next-state: region walk, bound latching, drain timing and write-address counters.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    in_start_d = in_start_q;
    in_fin_d   = in_fin_q;
    w_start_d  = w_start_q;
    w_fin_d    = w_fin_q;
    s_start_d  = s_start_q;
    s_fin_d    = s_fin_q;
    drain_d    = drain_q;
    err_d      = err_q;
    in_cnt_d   = input_wr_en_o ? in_cnt_q + INPUT_FEATURE_ADDR_WIDTH'(1) : in_cnt_q;
    ws_cnt_d   = weight_signal_wr_en_o ? ws_cnt_q + SIG_ADDRS_WIDTH'(1) : ws_cnt_q;
    go_in      = 1'b0;
    go_w       = 1'b0;
    go_s       = 1'b0;
    go_drain   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          in_start_d = input_start_addr_dram_i;
          in_fin_d   = input_finish_addr_dram_i;
          w_start_d  = weight_start_addr_dram_i;
          w_fin_d    = weight_finish_addr_dram_i;
          s_start_d  = signal_start_addr_dram_i;
          s_fin_d    = signal_finish_addr_dram_i;
          err_d      = ~(in_ok & w_ok & s_ok);
          in_cnt_d   = '0;
          ws_cnt_d   = '0;
          go_in      = 1'b1;
        end
      end
      StLdInput: begin
        if (addr_q == in_fin_q) go_w = 1'b1;
        else                    addr_d = addr_q + AW'(1);
      end
      StLdWeight: begin
        if (addr_q == w_fin_q) go_s = 1'b1;
        else                   addr_d = addr_q + AW'(1);
      end
      StLdSignal: begin
        if (addr_q == s_fin_q) go_drain = 1'b1;
        else                   addr_d = addr_q + AW'(1);
      end
      StDrain: begin
        if (drain_q == DrainLast) state_d = StDone;
        else                      drain_d = drain_q + 4'd1;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Enter the next region; skipped regions fall through to the one after.
    if (go_in) begin
      if (in_ok) begin
        state_d = StLdInput;
        addr_d  = eff_in_start;
      end else begin
        go_w = 1'b1;
      end
    end
    if (go_w) begin
      if (w_ok) begin
        state_d = StLdWeight;
        addr_d  = eff_w_start;
      end else begin
        go_s = 1'b1;
      end
    end
    if (go_s) begin
      if (s_ok) begin
        state_d = StLdSignal;
        addr_d  = eff_s_start;
      end else begin
        go_drain = 1'b1;
      end
    end
    if (go_drain) begin
      state_d = StDrain;
      drain_d = '0;
    end
  end

  // Read-latency pipeline: rd_en and its input/weight-signal tag travel together.
  always_comb begin
    pipe_en_d     = pipe_en_q;
    pipe_tag_d    = pipe_tag_q;
    pipe_en_d[0]  = rd_en;
    pipe_tag_d[0] = (state_q == StLdInput);
    for (int unsigned i = 1; i < DRAM_RD_LATENCY; i++) begin
      pipe_en_d[i]  = pipe_en_q[i-1];
      pipe_tag_d[i] = pipe_tag_q[i-1];
    end
  end

  // State registers with asynchronous reset that also flushes in-flight reads.
  always_ff @(posedge clk_i or posedge general_rst_i) begin
    if (general_rst_i) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      in_start_q <= '0;
      in_fin_q   <= '0;
      w_start_q  <= '0;
      w_fin_q    <= '0;
      s_start_q  <= '0;
      s_fin_q    <= '0;
      drain_q    <= '0;
      err_q      <= 1'b0;
      in_cnt_q   <= '0;
      ws_cnt_q   <= '0;
      pipe_en_q  <= '0;
      pipe_tag_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      in_start_q <= in_start_d;
      in_fin_q   <= in_fin_d;
      w_start_q  <= w_start_d;
      w_fin_q    <= w_fin_d;
      s_start_q  <= s_start_d;
      s_fin_q    <= s_fin_d;
      drain_q    <= drain_d;
      err_q      <= err_d;
      in_cnt_q   <= in_cnt_d;
      ws_cnt_q   <= ws_cnt_d;
      pipe_en_q  <= pipe_en_d;
      pipe_tag_q <= pipe_tag_d;
    end
  end

  assign dram_rd_en_o               = rd_en;
  assign dram_rd_address_o          = addr_q;
  assign input_wr_en_o              = pipe_en_q[DRAM_RD_LATENCY-1] & pipe_tag_q[DRAM_RD_LATENCY-1];
  assign weight_signal_wr_en_o      = pipe_en_q[DRAM_RD_LATENCY-1] & ~pipe_tag_q[DRAM_RD_LATENCY-1];
  assign input_wr_address_o         = in_cnt_q;
  assign weight_signal_wr_address_o = ws_cnt_q;
  assign busy_o                     = (state_q != StIdle);
  assign done_o                     = (state_q == StDone);

endmodule
